dpram_port_arbiter: RTL and testbench

Shares port A of the core's single-clock dual-port block RAM between three requesters, such as CPU, DMA/sprite copier and loader, using round-robin arbitration with a req/ack handshake.
After reset it optionally runs a clear sequence that writes zero to every RAM word before serving any requester.
It sits between the requesters and the RAM port A pins (wren_a, address_a, data_a, q_a). Port B is untouched.

---
 rtl/dpram_port_arbiter.sv | 103 ++++++++++
 tb/tb_dpram_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin arbiter sharing RAM port A between three requesters
// Optionally zero-fills the RAM after reset before serving any request.
module dpram_port_arbiter #(
  parameter int addr_width_g     = 8,
  parameter int data_width_g     = 8,
  parameter bit clear_on_reset_g = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [2:0]                   req,
  input  logic [2:0]                   we,
  input  logic [3*addr_width_g-1:0]    addr,
  input  logic [3*data_width_g-1:0]    wdata,
  output logic [2:0]                   ack,
  output logic [2:0]                   rvalid,
  output logic [data_width_g-1:0]      rdata,
  output logic                         busy,
  output logic                         ram_wren,
  output logic [addr_width_g-1:0]      ram_address,
  output logic [data_width_g-1:0]      ram_data,
  input  logic [data_width_g-1:0]      ram_q
);

  localparam logic [0:0] state_clear = 1'b0;
  localparam logic [0:0] state_run   = 1'b1;

  // One past the last RAM address: the clear is complete when the counter gets here.
  localparam logic [addr_width_g:0] clear_end = (addr_width_g + 1)'(1) << addr_width_g;

  logic [0:0]              state;
  logic [addr_width_g:0]   clear_cnt;
  logic [1:0]              ptr;

  logic [2:0]              eligible;
  logic                    grant_valid;
  logic [1:0]              grant_idx;
  logic [2:0]              cand_sum;
  logic [1:0]              cand;

  // A requester whose ack is showing this cycle is still holding its old req; mask it.
  always_comb begin
    eligible    = req & ~ack;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand_sum    = 3'd0;
    cand        = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand_sum = {1'b0, ptr} + 3'(k);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rdata = ram_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= clear_on_reset_g ? state_clear : state_run;
      busy        <= clear_on_reset_g;
      clear_cnt   <= '0;
      ptr         <= 2'd0;
      ack         <= 3'b000;
      rvalid      <= 3'b000;
      ram_wren    <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      ack    <= 3'b000;
      rvalid <= 3'b000;
      case (state)
        state_clear: begin
          if (clear_cnt == clear_end) begin
            state    <= state_run;
            busy     <= 1'b0;
            ram_wren <= 1'b0;
          end else begin
            ram_wren    <= 1'b1;
            ram_address <= clear_cnt[addr_width_g-1:0];
            ram_data    <= '0;
            clear_cnt   <= clear_cnt + 1'b1;
          end
        end
        default: begin
          // RAM q_a is valid the cycle after the issue cycle, so rvalid trails a read ack by one.
          rvalid <= ram_wren ? 3'b000 : ack;
          if (grant_valid) begin
            ack         <= 3'(1) << grant_idx;
            ram_wren    <= we[grant_idx];
            ram_address <= addr[int'(grant_idx)*addr_width_g +: addr_width_g];
            ram_data    <= wdata[int'(grant_idx)*data_width_g +: data_width_g];
            ptr         <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
          end else begin
            ram_wren <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - scoreboard bench for dpram_port_arbiter
// Instance a: 16-word RAM with clear; instance b: 256-word RAM without clear, random traffic.
module tb_dpram_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- instance a ----------------
  logic        reset_a;
  logic [2:0]  req_a, we_a, ack_a, rvalid_a;
  logic [11:0] addr_a;
  logic [23:0] wdata_a;
  logic [7:0]  rdata_a, data_a, q_a;
  logic [3:0]  address_a;
  logic        busy_a, wren_a;
  logic [7:0]  mem_a [16];
  logic        fill_a = 1'b0;

  dpram_port_arbiter #(.addr_width_g(4), .data_width_g(8), .clear_on_reset_g(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ack(ack_a), .rvalid(rvalid_a), .rdata(rdata_a), .busy(busy_a), .ram_wren(wren_a),
    .ram_address(address_a), .ram_data(data_a), .ram_q(q_a));

  always @(posedge clock) begin
    if (fill_a) for (int i = 0; i < 16; i++) mem_a[i] = 8'hFF;
    else if (wren_a) mem_a[address_a] = data_a;
    q_a <= mem_a[address_a];
  end

  // ---------------- instance b ----------------
  logic        reset_b;
  logic [2:0]  req_b, we_b, ack_b, rvalid_b;
  logic [23:0] addr_b;
  logic [23:0] wdata_b;
  logic [7:0]  rdata_b, data_b, q_b;
  logic [7:0]  address_b;
  logic        busy_b, wren_b;
  logic [7:0]  mem_b [256];
  logic        init_b = 1'b0;

  dpram_port_arbiter #(.addr_width_g(8), .data_width_g(8), .clear_on_reset_g(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ack(ack_b), .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b), .ram_wren(wren_b),
    .ram_address(address_b), .ram_data(data_b), .ram_q(q_b));

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  always @(posedge clock) begin
    if (init_b) for (int i = 0; i < 256; i++) mem_b[i] = init_val(i);
    else if (wren_b) mem_b[address_b] = data_b;
    q_b <= mem_b[address_b];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- stimulus queues and driver for b ----------------
  typedef struct packed { logic w; logic [7:0] a; logic [7:0] d; } acc_t;
  typedef struct packed { int c; logic [1:0] idx; logic w; logic [7:0] a; logic [7:0] d; } exp_t;

  acc_t pq0[$], pq1[$], pq2[$];
  exp_t ack_exp[$], rv_exp[$];
  int   order_log[$], order_ref[$];
  logic [7:0] rd_log[$];
  logic [2:0] active = 3'b000, got_ack = 3'b000;
  bit gen_en = 0, sb_en = 0, log_en = 0;
  logic [7:0] rmem [256];
  logic [2:0] mack = 3'b000;
  int mptr = 0;

  function automatic int pend_size(input int i);
    case (i)
      0: return pq0.size();
      1: return pq1.size();
      default: return pq2.size();
    endcase
  endfunction

  function automatic void push_acc(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    acc_t x;
    x.w = w; x.a = a; x.d = d;
    case (i)
      0: pq0.push_back(x);
      1: pq1.push_back(x);
      default: pq2.push_back(x);
    endcase
  endfunction

  function automatic acc_t pop_acc(input int i);
    acc_t x;
    case (i)
      0: x = pq0.pop_front();
      1: x = pq1.pop_front();
      default: x = pq2.pop_front();
    endcase
    return x;
  endfunction

  always @(negedge clock) got_ack = ack_b;

  initial begin : driver
    acc_t x;
    req_b = 3'b000; we_b = 3'b000; addr_b = '0; wdata_b = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (active[i] && got_ack[i]) active[i] = 1'b0;
        if (!active[i]) begin
          if (gen_en && pend_size(i) == 0 && $urandom_range(0, 2) == 0)
            push_acc(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
          if (pend_size(i) > 0) begin
            x = pop_acc(i);
            we_b[i] = x.w;
            addr_b[i*8 +: 8] = x.a;
            wdata_b[i*8 +: 8] = x.d;
            active[i] = 1'b1;
          end
        end
      end
      req_b = active;
    end
  end

  // Reference: round-robin rule applied to requests seen each cycle, RAM as a plain array.
  always @(negedge clock) begin : model
    logic [2:0] elig;
    int w;
    exp_t e;
    if (sb_en) begin
      elig = req_b & ~mack;
      w = -1;
      for (int k = 0; k < 3; k++)
        if (w < 0 && elig[(mptr + k) % 3]) w = (mptr + k) % 3;
      mack = 3'b000;
      if (w >= 0) begin
        mack[w] = 1'b1;
        mptr = (w + 1) % 3;
        e.c = cyc + 1;
        e.idx = w[1:0];
        e.w = we_b[w];
        e.a = addr_b[w*8 +: 8];
        e.d = wdata_b[w*8 +: 8];
        ack_exp.push_back(e);
        if (e.w) rmem[e.a] = e.d;
        else begin
          e.c = cyc + 2;
          e.d = rmem[e.a];
          rv_exp.push_back(e);
        end
      end
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb_en) begin
      if (ack_exp.size() > 0 && ack_exp[0].c == cyc) begin
        e = ack_exp.pop_front();
        chk("ack", ack_b, 3'(1) << e.idx);
        chk("ram_wren", wren_b, e.w);
        chk("ram_address", address_b, e.a);
        if (e.w) chk("ram_data", data_b, e.d);
      end else begin
        chk("idle_ack", ack_b, 0);
        chk("idle_wren", wren_b, 0);
      end
      if (log_en)
        for (int i = 0; i < 3; i++) if (ack_b[i]) order_log.push_back(i);
      if (rv_exp.size() > 0 && rv_exp[0].c == cyc) begin
        e = rv_exp.pop_front();
        chk("rvalid", rvalid_b, 3'(1) << e.idx);
        chk("rdata", rdata_b, e.d);
        if (log_en) rd_log.push_back(rdata_b);
      end else begin
        chk("idle_rvalid", rvalid_b, 0);
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((pq0.size() + pq1.size() + pq2.size() > 0 || active != 3'b000 ||
            ack_exp.size() > 0 || rv_exp.size() > 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk(name, n < 300, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_order(input string name);
    chk({name, "_len"}, order_log.size(), order_ref.size());
    for (int i = 0; i < order_ref.size() && i < order_log.size(); i++)
      chk(name, order_log[i], order_ref[i]);
  endtask

  // Watches a clear run on instance a; returns after busy falls or once abort_at has been written.
  task automatic watch_clear(input bit inject, input int abort_at, output int nw);
    nw = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (!busy_a) return;
      chk("clear_no_ack", {ack_a, rvalid_a}, 0);
      if (wren_a) begin
        chk("clear_addr", address_a, nw);
        chk("clear_data", data_a, 0);
        if (inject && nw == 3) begin
          req_a = 3'b100; we_a = 3'b000; addr_a[8 +: 4] = 4'h5;
        end
        nw++;
        if (abort_at >= 0 && nw - 1 == abort_at) return;
      end
    end
  endtask

  initial begin : main
    int nw, n;
    // ---- instance a: clear, request during clear, reset mid-clear ----
    reset_a = 1'b0; req_a = 3'b000; we_a = 3'b000; addr_a = '0; wdata_a = '0;
    reset_b = 1'b0;
    fill_a = 1'b1;
    init_b = 1'b1;
    for (int i = 0; i < 256; i++) rmem[i] = init_val(i);
    @(posedge clock);
    #1;
    fill_a = 1'b0;
    init_b = 1'b0;
    @(negedge clock);
    chk("a_reset_busy", busy_a, 1);
    chk("a_reset_wren", wren_a, 0);
    chk("a_reset_addr", address_a, 0);
    chk("a_reset_outs", {ack_a, rvalid_a}, 0);
    chk("b_reset_busy", busy_b, 0);
    chk("b_reset_outs", {ack_b, rvalid_b, wren_b, address_b, data_b}, 0);
    reset_a = 1'b1;
    watch_clear(1'b1, -1, nw);
    chk("clear_count", nw, 16);
    chk("ack_first_run_cycle", ack_a, 0);
    @(negedge clock);
    chk("ack_after_clear", ack_a, 3'b100);
    req_a = 3'b000;
    @(negedge clock);
    chk("rvalid_after_clear", rvalid_a, 3'b100);
    chk("rdata_after_clear", rdata_a, 0);
    for (int a = 0; a < 16; a++) begin
      addr_a[3:0] = a[3:0];
      we_a = 3'b000;
      req_a = 3'b001;
      n = 0;
      while (ack_a[0] !== 1'b1 && n < 6) begin
        @(negedge clock);
        n++;
      end
      chk("zero_rd_ack", n < 6, 1);
      req_a = 3'b000;
      @(negedge clock);
      chk("zero_rd_rvalid", rvalid_a, 3'b001);
      chk("zero_rd_data", rdata_a, 0);
    end
    reset_a = 1'b0;
    @(negedge clock);
    reset_a = 1'b1;
    watch_clear(1'b0, 7, nw);
    chk("abort_reached", nw, 8);
    reset_a = 1'b0;
    #1;
    chk("midclear_wren", wren_a, 0);
    chk("midclear_busy", busy_a, 1);
    chk("midclear_addr", address_a, 0);
    repeat (2) @(negedge clock);
    reset_a = 1'b1;
    watch_clear(1'b0, -1, nw);
    chk("restart_count", nw, 16);

    // ---- instance b: scoreboarded traffic ----
    reset_b = 1'b1;
    @(posedge clock);
    #1;
    mack = 3'b000;
    mptr = 0;
    sb_en = 1;
    @(negedge clock);
    log_en = 1;
    order_log.delete();
    push_acc(1, 1'b0, 8'h20, 8'h00);
    push_acc(2, 1'b0, 8'h30, 8'h00);
    drain("t6_drain");
    order_ref = '{1, 2};
    check_order("t6_order");

    order_log.delete();
    for (int r = 0; r < 2; r++) begin
      push_acc(0, 1'b0, 8'h01, 8'h00);
      push_acc(1, 1'b0, 8'h02, 8'h00);
      push_acc(2, 1'b0, 8'h03, 8'h00);
    end
    drain("t3_drain");
    order_ref = '{0, 1, 2, 0, 1, 2};
    check_order("t3_order");

    rd_log.delete();
    push_acc(0, 1'b1, 8'h12, 8'hA5);
    push_acc(0, 1'b0, 8'h12, 8'h00);
    drain("t2_drain");
    chk("t2_rdata", rd_log.size() > 0 ? 32'(rd_log[rd_log.size()-1]) : 32'hFFFF_FFFF, 8'hA5);

    log_en = 0;
    gen_en = 1;
    repeat (400) @(negedge clock);
    gen_en = 0;
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
